// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator slice.
//  - MIDI field widths (shared with the SPI front end and the voice controller)
//  - FSM state encoding for the allocator
//  - Latched MIDI event record
package voice_allocator_pkg;

    localparam int MIDI_NOTE_W = 7;
    localparam int MIDI_VEL_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_ISSUE  = 2'd3
    } alloc_state_t;

    // note_on holds the *effective* direction: a note-on with velocity 0
    // is already folded into a note-off when the event is latched.
    typedef struct packed {
        logic                   note_on;
        logic [MIDI_NOTE_W-1:0] note;
        logic [MIDI_VEL_W-1:0]  velocity;
    } midi_evt_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Bus between the event source / voice controller side and the allocator.
//  Event side : evt_valid, evt_note_on, evt_note, evt_velocity -> allocator,
//               evt_ready, evt_overflow <- allocator, overflow_clr -> allocator
//  Command side: cmd_valid, cmd_note_on, cmd_voice, cmd_note, cmd_velocity,
//               cmd_steal <- allocator, cmd_ready -> allocator
//  Status     : voice_active occupancy bitmap <- allocator
//  modport slave  = the allocator, modport master = its environment.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 8
);
    import voice_allocator_pkg::*;

    localparam int VOICE_W = $clog2(NUM_VOICES);

    logic                   evt_valid;
    logic                   evt_note_on;
    logic [MIDI_NOTE_W-1:0] evt_note;
    logic [MIDI_VEL_W-1:0]  evt_velocity;
    logic                   evt_ready;
    logic                   evt_overflow;
    logic                   overflow_clr;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_note_on;
    logic [VOICE_W-1:0]     cmd_voice;
    logic [MIDI_NOTE_W-1:0] cmd_note;
    logic [MIDI_VEL_W-1:0]  cmd_velocity;
    logic                   cmd_steal;

    logic [NUM_VOICES-1:0]  voice_active;

    modport slave (
        input  evt_valid, evt_note_on, evt_note, evt_velocity, overflow_clr, cmd_ready,
        output evt_ready, evt_overflow, cmd_valid, cmd_note_on, cmd_voice, cmd_note,
               cmd_velocity, cmd_steal, voice_active
    );

    modport master (
        output evt_valid, evt_note_on, evt_note, evt_velocity, overflow_clr, cmd_ready,
        input  evt_ready, evt_overflow, cmd_valid, cmd_note_on, cmd_voice, cmd_note,
               cmd_velocity, cmd_steal, voice_active
    );

endinterface

// File: rtl/voice_allocator_slot_table.sv
// voice_slot_table: per-slot active/note/age state.
//  clk, reset          : clock, asynchronous active-high reset
//  i_rd_idx            : read port address (scan index)
//  o_rd_active/note/age: read port data (combinational from the registers)
//  i_commit_*          : single commit port (slot, on/off, note)
//  o_active            : occupancy bitmap, bit i = slot i
module voice_slot_table
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [VOICE_W-1:0]     i_rd_idx,
    output logic                   o_rd_active,
    output logic [MIDI_NOTE_W-1:0] o_rd_note,
    output logic [AGE_W-1:0]       o_rd_age,
    input  logic                   i_commit_en,
    input  logic [VOICE_W-1:0]     i_commit_slot,
    input  logic                   i_commit_on,
    input  logic [MIDI_NOTE_W-1:0] i_commit_note,
    output logic [NUM_VOICES-1:0]  o_active
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic                   r_active [NUM_VOICES];
    logic [MIDI_NOTE_W-1:0] r_note   [NUM_VOICES];
    logic [AGE_W-1:0]       r_age    [NUM_VOICES];

    assign o_rd_active = r_active[i_rd_idx];
    assign o_rd_note   = r_note[i_rd_idx];
    assign o_rd_age    = r_age[i_rd_idx];

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
            logic w_hit;
            assign w_hit       = i_commit_en && (i_commit_slot == VOICE_W'(gi));
            assign o_active[gi] = r_active[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_active[gi] <= 1'b0;
                    r_note[gi]   <= '0;
                    r_age[gi]    <= '0;
                end else if (w_hit) begin
                    r_active[gi] <= i_commit_on;
                    r_age[gi]    <= '0;
                    if (i_commit_on)
                        r_note[gi] <= i_commit_note;
                end else if (i_commit_en && i_commit_on && r_active[gi] &&
                             (r_age[gi] != AGE_MAX)) begin
                    // a note-on elsewhere ages every other sounding slot
                    r_age[gi] <= r_age[gi] + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: picks a voice slot for each MIDI note event.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : voice_allocator_if.slave (event in, command out, occupancy,
//               overflow flag)
// Flow: IDLE latches an event, SCAN walks all slots one per cycle recording
// the first matching slot, the first free slot and the oldest active slot,
// DECIDE picks the target, ISSUE holds the command until cmd_ready.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    voice_allocator_if.slave     bus
);

    localparam int                 VOICE_W  = $clog2(NUM_VOICES);
    localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

    alloc_state_t r_state, w_state_next;

    midi_evt_t              r_evt;
    logic [VOICE_W-1:0]     r_scan_idx;
    logic                   r_match_found, r_free_found, r_old_found;
    logic [VOICE_W-1:0]     r_match_idx, r_free_idx, r_old_idx;
    logic [AGE_W-1:0]       r_old_age;

    logic                   r_cmd_on;
    logic [VOICE_W-1:0]     r_cmd_voice;
    logic [MIDI_NOTE_W-1:0] r_cmd_note;
    logic [MIDI_VEL_W-1:0]  r_cmd_vel;
    logic                   r_cmd_steal;
    logic                   r_overflow;

    logic                   w_latch_evt, w_scan_step, w_load_cmd, w_commit_en;
    logic                   w_rd_active;
    logic [MIDI_NOTE_W-1:0] w_rd_note;
    logic [AGE_W-1:0]       w_rd_age;
    logic [VOICE_W-1:0]     w_sel_voice;
    logic                   w_sel_steal;

    voice_slot_table #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .VOICE_W    (VOICE_W)
    ) u_table (
        .clk           (clk),
        .reset         (reset),
        .i_rd_idx      (r_scan_idx),
        .o_rd_active   (w_rd_active),
        .o_rd_note     (w_rd_note),
        .o_rd_age      (w_rd_age),
        .i_commit_en   (w_commit_en),
        .i_commit_slot (r_cmd_voice),
        .i_commit_on   (r_cmd_on),
        .i_commit_note (r_cmd_note),
        .o_active      (bus.voice_active)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_evt  = 1'b0;
        w_scan_step  = 1'b0;
        w_load_cmd   = 1'b0;
        w_commit_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.evt_valid) begin
                    w_latch_evt  = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_scan_step = 1'b1;
                if (r_scan_idx == LAST_IDX)
                    w_state_next = ST_DECIDE;
            end
            ST_DECIDE: begin
                // a release with no matching slot is dropped silently
                if (r_evt.note_on || r_match_found) begin
                    w_load_cmd   = 1'b1;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    w_commit_en  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Target priority: matching note, then lowest free slot, then oldest.
    // Releases only reach ISSUE with a match, so they always take the first arm.
    always_comb begin
        w_sel_voice = r_old_idx;
        w_sel_steal = 1'b1;
        if (r_match_found) begin
            w_sel_voice = r_match_idx;
            w_sel_steal = 1'b0;
        end else if (r_free_found) begin
            w_sel_voice = r_free_idx;
            w_sel_steal = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt         <= '0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_old_found   <= 1'b0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_cmd_on      <= 1'b0;
            r_cmd_voice   <= '0;
            r_cmd_note    <= '0;
            r_cmd_vel     <= '0;
            r_cmd_steal   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_latch_evt) begin
                r_evt.note_on  <= bus.evt_note_on && (bus.evt_velocity != '0);
                r_evt.note     <= bus.evt_note;
                r_evt.velocity <= bus.evt_velocity;
                r_scan_idx     <= '0;
                r_match_found  <= 1'b0;
                r_free_found   <= 1'b0;
                r_old_found    <= 1'b0;
            end

            if (w_scan_step) begin
                r_scan_idx <= r_scan_idx + 1'b1;
                if (w_rd_active && (w_rd_note == r_evt.note) && !r_match_found) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_scan_idx;
                end
                if (!w_rd_active && !r_free_found) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_scan_idx;
                end
                // strict '>' keeps the lowest index on equal ages
                if (w_rd_active && (!r_old_found || (w_rd_age > r_old_age))) begin
                    r_old_found <= 1'b1;
                    r_old_idx   <= r_scan_idx;
                    r_old_age   <= w_rd_age;
                end
            end

            if (w_load_cmd) begin
                r_cmd_on    <= r_evt.note_on;
                r_cmd_voice <= w_sel_voice;
                r_cmd_note  <= r_evt.note;
                r_cmd_vel   <= r_evt.note_on ? r_evt.velocity : '0;
                r_cmd_steal <= r_evt.note_on && w_sel_steal;
            end

            // set has priority over clear
            if (bus.evt_valid && (r_state != ST_IDLE))
                r_overflow <= 1'b1;
            else if (bus.overflow_clr)
                r_overflow <= 1'b0;
        end
    end

    assign bus.evt_ready    = (r_state == ST_IDLE);
    assign bus.cmd_valid    = (r_state == ST_ISSUE);
    assign bus.cmd_note_on  = r_cmd_on;
    assign bus.cmd_voice    = r_cmd_voice;
    assign bus.cmd_note     = r_cmd_note;
    assign bus.cmd_velocity = r_cmd_vel;
    assign bus.cmd_steal    = r_cmd_steal;
    assign bus.evt_overflow = r_overflow;

endmodule
